mailbox_sequencer: RTL and testbench

MAILBOX_SEQUENCER -- requirements
Module: mailbox_sequencer

---
 rtl/mailbox_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mailbox_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mailbox_sequencer.sv
// rtl/mailbox_sequencer.sv - host mailbox client transaction sequencer
module mailbox_sequencer #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned POLL_GAP      = 4,
    parameter logic [3:0]  TOP4_INIT     = 4'hA
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] MbDataIn,
    output logic [7:0] MbDataOut,
    output logic       MbDataOe,
    output logic       MbReadLine,
    output logic       MbWriteLine,
    output logic       MbStatusLine,
    output logic [7:0] RxData,
    output logic       RxIsCommand,
    output logic       RxValid,
    input  logic       RxReady,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    input  logic [3:0] Top4Data,
    input  logic       Top4Req,
    output logic       Top4Ack,
    output logic [7:0] StatusByte
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, EVAL, GAP} state_t;
    typedef enum logic [1:0] {POLL, RD, WR, SW} xfer_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD    = 4'(POLL_GAP - 1);
    localparam bit         GAP_SKIP    = (POLL_GAP == 0);

    state_t     state, state_nxt;
    xfer_t      xfer, xfer_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       last_rx;
    logic       sw_init;
    logic       rx_ok, tx_ok, strobe_done, enter_setup, in_txn_nxt;
    logic [3:0] sw_top4;

    // Eligibility is judged from the status byte captured by the last poll.
    assign rx_ok       = StatusByte[0] && !RxValid;
    assign tx_ok       = TxValid && !StatusByte[1];
    assign strobe_done = (state == STROBE) && (cnt == 4'd0);
    assign enter_setup = (state_nxt == SETUP) && (state != SETUP);
    assign in_txn_nxt  = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
    assign sw_top4     = (state == IDLE) ? TOP4_INIT : Top4Data;

    // Next-state and counter selection; outputs are registered from these below.
    always_comb begin
        state_nxt = state;
        xfer_nxt  = xfer;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = SETUP;
                xfer_nxt  = SW;
            end
            SETUP: begin
                state_nxt = STROBE;
                cnt_nxt   = STROBE_LOAD;
            end
            STROBE: begin
                if (cnt == 4'd0) state_nxt = HOLD;
                else             cnt_nxt   = cnt - 4'd1;
            end
            HOLD: begin
                if (xfer == POLL) begin
                    state_nxt = EVAL;
                end else if (GAP_SKIP) begin
                    state_nxt = SETUP;
                    xfer_nxt  = POLL;
                end else begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            EVAL: begin
                if (Top4Req) begin
                    state_nxt = SETUP;
                    xfer_nxt  = SW;
                end else if (rx_ok && !(tx_ok && last_rx)) begin
                    state_nxt = SETUP;
                    xfer_nxt  = RD;
                end else if (tx_ok) begin
                    state_nxt = SETUP;
                    xfer_nxt  = WR;
                end else if (GAP_SKIP) begin
                    state_nxt = SETUP;
                    xfer_nxt  = POLL;
                end else begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt == 4'd0) begin
                    state_nxt = SETUP;
                    xfer_nxt  = POLL;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and all registered outputs; strobes derive from the next state so they never glitch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            xfer         <= POLL;
            cnt          <= 4'd0;
            last_rx      <= 1'b1;
            sw_init      <= 1'b0;
            MbDataOut    <= 8'h00;
            MbDataOe     <= 1'b0;
            MbReadLine   <= 1'b0;
            MbWriteLine  <= 1'b0;
            MbStatusLine <= 1'b0;
            RxData       <= 8'h00;
            RxIsCommand  <= 1'b0;
            RxValid      <= 1'b0;
            TxReady      <= 1'b0;
            Top4Ack      <= 1'b0;
            StatusByte   <= 8'h00;
        end else begin
            state <= state_nxt;
            xfer  <= xfer_nxt;
            cnt   <= cnt_nxt;

            MbStatusLine <= in_txn_nxt && (xfer_nxt == POLL || xfer_nxt == SW);
            MbDataOe     <= in_txn_nxt && (xfer_nxt == WR || xfer_nxt == SW);
            MbReadLine   <= (state_nxt == STROBE) && (xfer_nxt == POLL || xfer_nxt == RD);
            MbWriteLine  <= (state_nxt == STROBE) && (xfer_nxt == WR || xfer_nxt == SW);
            TxReady      <= (state_nxt == SETUP) && (xfer_nxt == WR);
            Top4Ack      <= (state_nxt == HOLD) && (xfer_nxt == SW) && !sw_init;

            // The power-on Top4 write is not acknowledged to the requester.
            if (state == IDLE)      sw_init <= 1'b1;
            else if (state == HOLD) sw_init <= 1'b0;

            if (enter_setup) begin
                if (xfer_nxt == WR)      MbDataOut <= TxData;
                else if (xfer_nxt == SW) MbDataOut <= {sw_top4, 4'h0};
            end

            if (state == EVAL && enter_setup) begin
                if (xfer_nxt == RD)      last_rx <= 1'b1;
                else if (xfer_nxt == WR) last_rx <= 1'b0;
            end

            if (RxValid && RxReady) RxValid <= 1'b0;

            if (strobe_done) begin
                case (xfer)
                    POLL: StatusByte <= MbDataIn;
                    RD: begin
                        RxData      <= MbDataIn;
                        RxIsCommand <= StatusByte[2];
                        RxValid     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mailbox_sequencer.sv
// tb/tb_mailbox_sequencer.sv - directed self-checking bench for mailbox_sequencer
module tb_mailbox_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [7:0] status_val = 8'hA0;
    logic [7:0] host_byte = 8'h00;
    logic [7:0] mb_data_in;
    logic [7:0] mb_data_out;
    logic       mb_data_oe, mb_read_line, mb_write_line, mb_status_line;
    logic [7:0] rx_data;
    logic       rx_is_command, rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [3:0] top4_data = 4'h0;
    logic       top4_req = 1'b0;
    logic       top4_ack;
    logic [7:0] status_byte;

    logic       f_reset = 1'b1;
    logic [7:0] f_mb_data_in = 8'h00;
    logic [7:0] f_mb_data_out, f_rx_data, f_status_byte;
    logic       f_oe, f_rd, f_wr, f_st, f_rx_cmd, f_rx_valid, f_tx_ready, f_ack;
    logic       f_rx_ready = 1'b0;
    logic [7:0] f_tx_data = 8'h00;
    logic       f_tx_valid = 1'b0;
    logic [3:0] f_top4_data = 4'h0;
    logic       f_top4_req = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // Mailbox client: status register while the status qualifier is high, host byte otherwise.
    assign mb_data_in = mb_status_line ? status_val : host_byte;

    mailbox_sequencer dut (
        .Clk(clk), .Reset(reset), .MbDataIn(mb_data_in), .MbDataOut(mb_data_out),
        .MbDataOe(mb_data_oe), .MbReadLine(mb_read_line), .MbWriteLine(mb_write_line),
        .MbStatusLine(mb_status_line), .RxData(rx_data), .RxIsCommand(rx_is_command),
        .RxValid(rx_valid), .RxReady(rx_ready), .TxData(tx_data), .TxValid(tx_valid),
        .TxReady(tx_ready), .Top4Data(top4_data), .Top4Req(top4_req), .Top4Ack(top4_ack),
        .StatusByte(status_byte)
    );

    mailbox_sequencer #(.STROBE_CYCLES(1), .POLL_GAP(0)) dut_fast (
        .Clk(clk), .Reset(f_reset), .MbDataIn(f_mb_data_in), .MbDataOut(f_mb_data_out),
        .MbDataOe(f_oe), .MbReadLine(f_rd), .MbWriteLine(f_wr), .MbStatusLine(f_st),
        .RxData(f_rx_data), .RxIsCommand(f_rx_cmd), .RxValid(f_rx_valid), .RxReady(f_rx_ready),
        .TxData(f_tx_data), .TxValid(f_tx_valid), .TxReady(f_tx_ready), .Top4Data(f_top4_data),
        .Top4Req(f_top4_req), .Top4Ack(f_ack), .StatusByte(f_status_byte)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] obs;
        reset = 1'b1;
        tick;
        tick;
        obs = {mb_status_line, mb_write_line, mb_read_line, mb_data_oe, top4_ack, tx_ready, rx_valid, rx_is_command};
        tests_run++;
        if (obs !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected %b", obs, 8'h00);
        end
        tests_run++;
        if (mb_data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data_out: got %h expected 00", mb_data_out);
        end
        tests_run++;
        if ({rx_data, status_byte} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_rx_status: got %h expected 0000", {rx_data, status_byte});
        end
        reset = 1'b0;
    endtask

    task automatic test_sw_init;
        logic [3:0] exp_tab [13];
        logic [5:0] obs, exp;
        exp_tab = '{4'b1001, 4'b1101, 4'b1101, 4'b1001, 4'b0000, 4'b0000, 4'b0000,
                    4'b0000, 4'b1000, 4'b1010, 4'b1010, 4'b1000, 4'b0000};
        for (int c = 1; c <= 13; c++) begin
            tick;
            obs = {mb_status_line, mb_write_line, mb_read_line, mb_data_oe, top4_ack, tx_ready};
            exp = {exp_tab[c-1], 2'b00};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL sw_init cycle %0d: got %b expected %b", c, obs, exp);
            end
            if (c == 1) begin
                tests_run++;
                if (mb_data_out !== 8'hA0) begin
                    tests_failed++;
                    $display("FAIL sw_init_data: got %h expected a0", mb_data_out);
                end
            end
            if (c == 12) begin
                tests_run++;
                if (status_byte !== 8'hA0) begin
                    tests_failed++;
                    $display("FAIL poll_capture: got %h expected a0", status_byte);
                end
            end
        end
    endtask

    task automatic test_rd;
        logic [4:0] exp_tab [4];
        logic [4:0] obs;
        int second_rd, rxv_low;
        bit found;
        exp_tab = '{5'b00000, 5'b00100, 5'b00100, 5'b00001};
        status_val = 8'h05;
        host_byte  = 8'h5A;
        rx_ready   = 1'b0;
        do_reset;
        repeat (13) tick;
        tests_run++;
        if (status_byte !== 8'h05) begin
            tests_failed++;
            $display("FAIL rd_status: got %h expected 05", status_byte);
        end
        for (int c = 14; c <= 17; c++) begin
            tick;
            obs = {mb_status_line, mb_write_line, mb_read_line, mb_data_oe, rx_valid};
            tests_run++;
            if (obs !== exp_tab[c-14]) begin
                tests_failed++;
                $display("FAIL rd cycle %0d: got %b expected %b", c, obs, exp_tab[c-14]);
            end
        end
        tests_run++;
        if ({rx_data, rx_is_command} !== {8'h5A, 1'b1}) begin
            tests_failed++;
            $display("FAIL rd_data: got %h/%b expected 5a/1", rx_data, rx_is_command);
        end
        second_rd = 0;
        rxv_low = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (mb_read_line && !mb_status_line) second_rd++;
            if (!rx_valid) rxv_low++;
        end
        tests_run++;
        if (second_rd !== 0 || rxv_low !== 0) begin
            tests_failed++;
            $display("FAIL rd_hold: got rd=%0d low=%0d expected 0/0", second_rd, rxv_low);
        end
        rx_ready = 1'b1;
        tick;
        rx_ready = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_consume: got %b expected 0", rx_valid);
        end
        host_byte = 8'hC3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick;
            if (rx_valid) found = 1'b1;
        end
        tests_run++;
        if (!found || rx_data !== 8'hC3) begin
            tests_failed++;
            $display("FAIL rd_again: got found=%b data=%h expected 1/c3", found, rx_data);
        end
    endtask

    task automatic test_wr;
        logic [4:0] exp_tab [5];
        logic [4:0] obs;
        int bad;
        exp_tab = '{5'b00011, 5'b01010, 5'b01010, 5'b00010, 5'b00000};
        status_val = 8'h00;
        tx_data    = 8'h3C;
        tx_valid   = 1'b1;
        do_reset;
        repeat (13) tick;
        for (int c = 14; c <= 18; c++) begin
            tick;
            obs = {mb_status_line, mb_write_line, mb_read_line, mb_data_oe, tx_ready};
            tests_run++;
            if (obs !== exp_tab[c-14]) begin
                tests_failed++;
                $display("FAIL wr cycle %0d: got %b expected %b", c, obs, exp_tab[c-14]);
            end
            if (c == 14) begin
                tests_run++;
                if (mb_data_out !== 8'h3C) begin
                    tests_failed++;
                    $display("FAIL wr_data: got %h expected 3c", mb_data_out);
                end
            end
            if (c == 15) tx_valid = 1'b0;
        end
        status_val = 8'h02;
        tx_data    = 8'h55;
        tx_valid   = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (tx_ready || (mb_write_line && !mb_status_line)) bad++;
        end
        tx_valid = 1'b0;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL wr_blocked: got %0d write cycles expected 0", bad);
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] seq;
        int n, other, acks;
        bit got_ack;
        status_val = 8'h01;
        host_byte  = 8'h22;
        tx_data    = 8'h11;
        tx_valid   = 1'b1;
        rx_ready   = 1'b1;
        do_reset;
        seq = 8'h00;
        n = 0;
        for (int i = 0; i < 300 && n < 4; i++) begin
            tick;
            if (tx_ready) begin seq = {seq[5:0], 2'd1}; n++; end
            if (rx_valid) begin seq = {seq[5:0], 2'd2}; n++; end
        end
        tests_run++;
        if (n !== 4 || seq !== 8'b01_10_01_10) begin
            tests_failed++;
            $display("FAIL rr_order: got n=%0d seq=%b expected 4/01100110", n, seq);
        end
        top4_data = 4'h7;
        top4_req  = 1'b1;
        other = 0;
        acks = 0;
        got_ack = 1'b0;
        for (int i = 0; i < 60 && !got_ack; i++) begin
            tick;
            if (tx_ready || rx_valid) other++;
            if (top4_ack) begin
                got_ack = 1'b1;
                acks++;
                tests_run++;
                if ({mb_data_oe, mb_status_line, mb_write_line, mb_read_line, mb_data_out} !== {4'b1100, 8'h70}) begin
                    tests_failed++;
                    $display("FAIL sw_hold: got %b/%h expected 1100/70",
                             {mb_data_oe, mb_status_line, mb_write_line, mb_read_line}, mb_data_out);
                end
                top4_req = 1'b0;
            end
        end
        top4_req = 1'b0;
        tests_run++;
        if (!got_ack || other !== 0) begin
            tests_failed++;
            $display("FAIL sw_priority: got ack=%b others=%0d expected 1/0", got_ack, other);
        end
        for (int i = 0; i < 30; i++) begin
            tick;
            if (top4_ack) acks++;
        end
        tests_run++;
        if (acks !== 1) begin
            tests_failed++;
            $display("FAIL ack_pulses: got %0d expected 1", acks);
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wr;
        logic [4:0] exp_tab [4];
        logic [4:0] obs;
        bit found;
        exp_tab = '{5'b10010, 5'b11010, 5'b11010, 5'b10010};
        status_val = 8'h00;
        tx_data    = 8'h3C;
        tx_valid   = 1'b1;
        do_reset;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick;
            if (mb_write_line && !mb_status_line) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL abort_find_wr: got 0 expected 1");
        end
        reset = 1'b1;
        tick;
        obs = {mb_write_line, mb_data_oe, tx_ready, mb_status_line, mb_read_line};
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("FAIL abort_lines: got %b expected 00000", obs);
        end
        reset = 1'b0;
        tx_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick;
            obs = {mb_status_line, mb_write_line, mb_read_line, mb_data_oe, top4_ack};
            tests_run++;
            if (obs !== exp_tab[c-1]) begin
                tests_failed++;
                $display("FAIL restart cycle %0d: got %b expected %b", c, obs, exp_tab[c-1]);
            end
            if (c == 1) begin
                tests_run++;
                if (mb_data_out !== 8'hA0) begin
                    tests_failed++;
                    $display("FAIL restart_data: got %h expected a0", mb_data_out);
                end
            end
        end
    endtask

    task automatic test_fast_poll;
        int rises [8];
        int nrise, viol, rd_cnt;
        logic prev_st;
        f_reset = 1'b1;
        tick;
        tick;
        f_reset = 1'b0;
        nrise = 0;
        viol = 0;
        rd_cnt = 0;
        prev_st = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick;
            if (f_st && !prev_st && nrise < 8) begin
                rises[nrise] = c;
                nrise++;
            end
            if (f_rd && (!f_st || !prev_st)) viol++;
            if (f_rd) rd_cnt++;
            prev_st = f_st;
        end
        tests_run++;
        if (nrise < 4) begin
            tests_failed++;
            $display("FAIL fast_rises: got %0d expected >=4", nrise);
        end else begin
            tests_run++;
            if (rises[1] !== 8 || rises[2] - rises[1] !== 4 || rises[3] - rises[2] !== 4) begin
                tests_failed++;
                $display("FAIL fast_spacing: got %0d,%0d,%0d expected 8,12,16", rises[1], rises[2], rises[3]);
            end
        end
        tests_run++;
        if (viol !== 0 || rd_cnt !== 7) begin
            tests_failed++;
            $display("FAIL fast_read: got viol=%0d reads=%0d expected 0/7", viol, rd_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_sw_init;
        test_rd;
        test_wr;
        test_round_robin;
        test_reset_mid_wr;
        test_fast_poll;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
